// File: rtl/bsg_yumi_to_ready_fifo.sv
// bsg_yumi_to_ready_fifo
//
// Small circular-buffer FIFO that drains an upstream valid/yumi producer and
// presents the data downstream on a ready/valid interface. It is the
// consuming end of valid/yumi: yumi_o is raised only when a slot is free, and
// accepted data becomes visible on the following cycle (no bypass). With two
// entries it sustains one transfer per cycle, and no downstream control signal
// reaches the upstream side combinationally.
//
// Ports:
//   clk_i    in   1        clock, all state updates on the rising edge
//   reset_i  in   1        asynchronous, active-high reset
//   v_i      in   1        upstream data valid
//   data_i   in   width_p  upstream data, captured when yumi_o=1
//   yumi_o   out  1        upstream consume strobe (transfer this cycle)
//   v_o      out  1        downstream data valid
//   data_o   out  width_p  head-of-queue data, don't-care while v_o=0
//   ready_i  in   1        downstream ready, transfer when v_o & ready_i
//
// Parameters:
//   width_p  data width in bits
//   els_p    number of entries, at least 2 and a power of two

module bsg_yumi_to_ready_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               yumi_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    localparam int ptr_w_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int count_w_lp = $clog2(els_p + 1);

    localparam logic [count_w_lp-1:0] els_count_lp = count_w_lp'(els_p);

    logic [ptr_w_lp-1:0]   rptr_r;
    logic [ptr_w_lp-1:0]   wptr_r;
    logic [count_w_lp-1:0] count_r;
    logic [count_w_lp-1:0] count_n_s;
    logic                  full_r;
    logic                  v_r;
    logic [width_p-1:0]    mem_r [els_p];

    logic                  enq_s;
    logic                  deq_s;

    // Transfer strobes. full_r and v_r are registered copies of the
    // occupancy flags, so the only combinational path to an output is
    // v_i -> yumi_o. Reset masks yumi_o so nothing is accepted while held.
    always_comb begin
        yumi_o = v_i & ~full_r & ~reset_i;
        enq_s  = yumi_o;
        deq_s  = v_r & ready_i;
        v_o    = v_r;
        data_o = mem_r[rptr_r];
    end

    // Next occupancy: simultaneous enq and deq leave the count unchanged.
    always_comb begin
        count_n_s = count_r;
        case ({enq_s, deq_s})
            2'b10:   count_n_s = count_r + count_w_lp'(1);
            2'b01:   count_n_s = count_r - count_w_lp'(1);
            2'b11:   count_n_s = count_r;
            2'b00:   count_n_s = count_r;
            default: count_n_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered flags. Pointers wrap naturally
    // because els_p is a power of two.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r  <= ptr_w_lp'(0);
            wptr_r  <= ptr_w_lp'(0);
            count_r <= count_w_lp'(0);
            full_r  <= 1'b0;
            v_r     <= 1'b0;
        end else begin
            if (enq_s) begin
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (deq_s) begin
                rptr_r <= rptr_r + ptr_w_lp'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            count_r <= count_n_s;
            full_r  <= (count_n_s == els_count_lp);
            v_r     <= (count_n_s != count_w_lp'(0));
        end
    end

    // Storage array, deliberately not reset; only written on an accept.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[wptr_r] <= data_i;
        end
    end

endmodule

// File: doc/bsg_yumi_to_ready_fifo.md
# bsg_yumi_to_ready_fifo

Small circular-buffer FIFO that drains an upstream valid/yumi producer, such as a single-entry valid/yumi FIFO, and presents the data downstream on a ready/valid interface. It is the consuming end of the valid/yumi protocol: it generates yumi only when it can accept, and it re-times data by one cycle. With the default two entries it sustains one transfer per cycle while keeping every downstream-to-upstream control path registered.

## Interface
- width_p, 32, data width in bits.
- els_p, 2, number of storage entries. Must be ≥ 2 and a power of two.

Ports:
- clk_i  in  1  the single clock; all state is updated on its rising edge.
- reset_i  in  1  reset, asynchronous and active-high.
- v_i  in  1  upstream data valid.
- data_i  in  width_p  upstream data; sampled when yumi_o=1.
- yumi_o  out  1  upstream consume strobe; the transfer occurs in this cycle.
- v_o  out  1  downstream data valid.
- data_o  out  width_p  head-of-queue data.
- ready_i  in  1  downstream ready; a transfer occurs when v_o & ready_i.

## Operation
- State: read pointer rptr and write pointer wptr, each log2(els_p) bits; occupancy count of $clog2(els_p+1) bits; storage array mem[els_p].
- full = (count == els_p). empty = (count == 0).
- yumi_o = v_i & ~full. It is never asserted while v_i=0. It has no dependence on ready_i.
- enq = yumi_o. On enq: mem[wptr] <= data_i and wptr <= wptr+1.
- deq = v_o & ready_i. On deq: rptr <= rptr+1.
- Pointers wrap modulo els_p (natural overflow, since els_p is a power of two).
- count update:
  - enq & ~deq: count+1.
  - deq & ~enq: count−1.
  - both or neither: unchanged.
- v_o = ~empty. data_o = mem[rptr]. data_o is don't-care while v_o=0.
- No bypass: data enqueued while empty is first visible on the next cycle.
- When full and deq occurs in the same cycle, yumi_o stays 0 that cycle. The freed slot is offered on the following cycle.
- When empty, v_i=1 and ready_i=1: enq only. Nothing is dequeued.
- Storage is not reset. Pointers and count are.

## Timing
- Reset (asynchronous assert, any time): rptr=0, wptr=0, count=0 immediately. This gives v_o=0 and yumi_o=0 (full=0, so yumi_o follows v_i once reset deasserts).
- Reset in mid-operation discards all buffered entries. No partial transfer is recorded.
- While reset_i=1, yumi_o is forced to 0.
- Latency from upstream accept to v_o=1 is 1 cycle.
- Throughput is 1 item per cycle in steady state with ready_i held high.
- Combinational paths: v_i→yumi_o. Every other output comes from a register or a storage read.
- Ordering is strictly FIFO. No item is dropped or duplicated.

## Test plan
- Reset/idle:
  - Assert reset_i asynchronously mid-cycle with 1 item buffered → v_o=0 immediately.
  - After release, v_i=0 → yumi_o=0 and v_o=0 on every cycle.
- Single item:
  - v_i=1 with data_i=0xDEADBEEF for one cycle, ready_i=0 → yumi_o=1 that cycle.
  - Next cycle → v_o=1, data_o=0xDEADBEEF.
  - Raise ready_i → v_o=0 one cycle later.
- Fill and backpressure (els_p=2):
  - Present 0x1, 0x2, 0x3 back-to-back with ready_i=0 → yumi_o=1,1,0. count saturates at 2. v_i stays high on 0x3 with no accept.
  - Raise ready_i → outputs 0x1, 0x2, 0x3 in order. 0x3 is accepted the cycle after 0x1 leaves.
- Full with simultaneous dequeue: full and ready_i=1 → yumi_o=0 that cycle. Next cycle yumi_o=1 and count returns to 2.
- Streaming and wrap-around: 100 sequential values with v_i and ready_i held at 1 → yumi_o=1 every cycle after the first. Output sequence is identical and delayed by 1 cycle. Pointers wrap repeatedly with no loss.
- Random v_i/ready_i (10k cycles) against a scoreboard:
  - Order is preserved.
  - yumi_o is never 1 while v_i=0.
  - count is never above els_p.
